// File: rtl/pc_out_arbiter_if.sv
// pc_out_arbiter_if: word-stream bundle between N_IN serialized sources and the PC-bound channel.
//   in_d/in_last/in_v/in_a : per-source packed words, end-of-packet flags, valids and acks
//   out_d/out_v/out_a      : merged output word, valid and downstream ack
//   master = sources + downstream sink, slave = arbiter
interface pc_out_arbiter_if #(
    parameter int N_IN = 3,
    parameter int NW   = 35
);
    logic [N_IN*NW-1:0] in_d;
    logic [N_IN-1:0]    in_last;
    logic [N_IN-1:0]    in_v;
    logic [N_IN-1:0]    in_a;
    logic [NW-1:0]      out_d;
    logic               out_v;
    logic               out_a;
    modport master (output in_d, in_last, in_v, out_a, input in_a, out_d, out_v);
    modport slave  (input in_d, in_last, in_v, out_a, output in_a, out_d, out_v);
endinterface

// File: rtl/pc_out_arbiter.sv
// pc_out_arbiter: weighted round-robin, packet-atomic merge of N_IN word sources onto one registered output.
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : per-source in_d/in_last/in_v/in_a, merged out_d/out_v/out_a
//   weights     : per-source packet quota (NQ bits each), 0 disables the source
//   busy        : a grant is active
//   grant_idx   : current/last granted source
//   Optional PC_OUT_ARB_STATS_EN adds stats_clr (sync clear) and pkt_count (N_IN x 16-bit saturating packet counters).
module pc_out_arbiter #(
    parameter int N_IN = 3,
    parameter int NW   = 35,
    parameter int NQ   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    pc_out_arbiter_if.slave          bus,
    input  logic [N_IN*NQ-1:0]       weights,
    output logic                     busy,
    output logic [$clog2(N_IN)-1:0]  grant_idx
`ifdef PC_OUT_ARB_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [N_IN*16-1:0]       pkt_count
`endif
);
    localparam int NG = $clog2(N_IN);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          r_state;
    logic [NG-1:0]   r_rr_ptr;
    logic [NG-1:0]   r_grant_idx;
    logic [NQ-1:0]   r_quota;
    logic            r_mid_pkt;
    logic [NW-1:0]   r_out_d;
    logic            r_out_v;
    logic            w_found;
    logic [NG-1:0]   w_win;
    int              w_j;
    logic            w_xfer;
    logic            w_last;
    logic [NQ-1:0]   w_qdec;
    logic [NG-1:0]   w_next;
    // Acks only flow to the granted source and only when the output register can accept a word.
    assign bus.in_a  = (r_state == GRANT && (!r_out_v || bus.out_a)) ? N_IN'(1) << r_grant_idx : '0;
    assign bus.out_d = r_out_d;
    assign bus.out_v = r_out_v;
    assign busy      = (r_state == GRANT);
    assign grant_idx = r_grant_idx;
    assign w_xfer    = bus.in_v[r_grant_idx] && bus.in_a[r_grant_idx];
    assign w_last    = bus.in_last[r_grant_idx];
    assign w_qdec    = r_quota - 1'b1;
    assign w_next    = (r_grant_idx == NG'(N_IN - 1)) ? '0 : r_grant_idx + 1'b1;
    // Walk candidates from the highest offset down so the one closest to rr_ptr is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            w_j = int'(r_rr_ptr) + k;
            w_j = (w_j >= N_IN) ? w_j - N_IN : w_j;
            if (bus.in_v[w_j] && weights[w_j*NQ +: NQ] != '0) begin
                w_found = 1'b1;
                w_win   = NG'(w_j);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_quota     <= '0;
            r_mid_pkt   <= 1'b0;
            r_out_d     <= '0;
            r_out_v     <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_d <= bus.in_d[r_grant_idx*NW +: NW];
                r_out_v <= 1'b1;
            end else if (bus.out_a) begin
                r_out_v <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (w_found) begin
                    r_grant_idx <= w_win;
                    r_quota     <= weights[w_win*NQ +: NQ];
                    r_state     <= GRANT;
                end
            end else if (w_xfer) begin
                r_mid_pkt <= !w_last;
                if (w_last) begin
                    r_quota <= w_qdec;
                    if (w_qdec == '0) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next;
                    end
                end
            end else if (!r_mid_pkt && !bus.in_v[r_grant_idx]) begin
                // Source went quiet at a packet boundary: give others a turn.
                r_state  <= IDLE;
                r_rr_ptr <= w_next;
            end
        end
    end
`ifdef PC_OUT_ARB_STATS_EN
    logic [N_IN-1:0][15:0] r_cnt;
    assign pkt_count = r_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (stats_clr)
                    r_cnt[i] <= '0;
                else if (w_xfer && w_last && r_grant_idx == NG'(i) && r_cnt[i] != 16'hFFFF)
                    r_cnt[i] <= r_cnt[i] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_pc_out_arbiter.sv
// tb_pc_out_arbiter: directed self-checking bench for pc_out_arbiter (stats tests when PC_OUT_ARB_STATS_EN is defined).
module tb_pc_out_arbiter;
    localparam int N_IN = 3;
    localparam int NW   = 35;
    localparam int NQ   = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N_IN*NQ-1:0] weights = '0;
    logic busy;
    logic [1:0] grant_idx;
    logic [N_IN-1:0] hold = '0;
    logic ack1_seen = 1'b0;
    logic [NW:0] src_q [N_IN][$];
    logic [NW-1:0] mon_q [$];
    int checks = 0;
    int failures = 0;
`ifdef PC_OUT_ARB_STATS_EN
    logic stats_clr = 1'b0;
    logic [N_IN*16-1:0] pkt_count;
`endif

    pc_out_arbiter_if #(.N_IN(N_IN), .NW(NW)) bus ();

    pc_out_arbiter #(.N_IN(N_IN), .NW(NW), .NQ(NQ)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .weights(weights),
        .busy(busy),
        .grant_idx(grant_idx)
`ifdef PC_OUT_ARB_STATS_EN
        ,
        .stats_clr(stats_clr),
        .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NW-1:0] wd(int s, int p, int k);
        return NW'(s * 256 + p * 16 + k);
    endfunction

    function automatic logic [N_IN*NQ-1:0] wts(int a, int b, int c);
        return {NQ'(c), NQ'(b), NQ'(a)};
    endfunction

    task automatic drive();
        logic [NW:0] e;
        for (int i = 0; i < N_IN; i++) begin
            e = src_q[i].size() > 0 ? src_q[i][0] : '0;
            bus.in_v[i] = src_q[i].size() > 0 && !hold[i];
            bus.in_d[i*NW +: NW] = e[NW-1:0];
            bus.in_last[i] = e[NW];
        end
    endtask

    // Source models pop on handshake; sink monitor records accepted output words.
    initial begin
        drive();
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int i = 0; i < N_IN; i++)
                    if (bus.in_v[i] && bus.in_a[i]) void'(src_q[i].pop_front());
                if (bus.out_v && bus.out_a) mon_q.push_back(bus.out_d);
                if (bus.in_a[1] === 1'b1) ack1_seen = 1'b1;
            end
            #1 drive();
            @(negedge clk);
            #1 drive();
        end
    end

    task automatic do_reset(input logic [N_IN*NQ-1:0] w);
        reset = 1'b1;
        for (int i = 0; i < N_IN; i++) src_q[i].delete();
        mon_q.delete();
        hold = '0;
        bus.out_a = 1'b1;
        weights = w;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_mon(input int n);
        for (int c = 0; c < 300 && mon_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.out_v !== 1'b0) begin failures++; $display("FAIL reset_out_v: got %b expected 0", bus.out_v); end
        checks++; if (bus.out_d !== '0) begin failures++; $display("FAIL reset_out_d: got %h expected 0", bus.out_d); end
        checks++; if (bus.in_a !== '0) begin failures++; $display("FAIL reset_in_a: got %b expected 000", bus.in_a); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_source();
        do_reset(wts(1, 1, 1));
        src_q[0].push_back({1'b1, 35'h1});
        src_q[0].push_back({1'b1, 35'h2});
        src_q[0].push_back({1'b1, 35'h3});
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ss_busy: got %b expected 1", busy); end
        checks++; if (bus.out_v !== 1'b0) begin failures++; $display("FAIL ss_bubble0: got %b expected 0", bus.out_v); end
        @(negedge clk);
        checks++; if (bus.out_v !== 1'b1 || bus.out_d !== 35'h1) begin failures++; $display("FAIL ss_word1: got v=%b d=%h expected v=1 d=1", bus.out_v, bus.out_d); end
        @(negedge clk);
        checks++; if (bus.out_v !== 1'b0) begin failures++; $display("FAIL ss_bubble1: got %b expected 0", bus.out_v); end
        @(negedge clk);
        checks++; if (bus.out_v !== 1'b1 || bus.out_d !== 35'h2) begin failures++; $display("FAIL ss_word2: got v=%b d=%h expected v=1 d=2", bus.out_v, bus.out_d); end
        @(negedge clk);
        checks++; if (bus.out_v !== 1'b0) begin failures++; $display("FAIL ss_bubble2: got %b expected 0", bus.out_v); end
        @(negedge clk);
        checks++; if (bus.out_v !== 1'b1 || bus.out_d !== 35'h3) begin failures++; $display("FAIL ss_word3: got v=%b d=%h expected v=1 d=3", bus.out_v, bus.out_d); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.out_v !== 1'b0) begin failures++; $display("FAIL ss_done: got busy=%b v=%b expected 0 0", busy, bus.out_v); end
    endtask

    task automatic test_back_to_back();
        int ord [8] = '{0, 0, 1, 2, 0, 0, 1, 2};
        int pc [N_IN] = '{0, 0, 0};
        int n;
        logic [NW-1:0] exp;
        do_reset(wts(2, 1, 1));
        for (int s = 0; s < N_IN; s++)
            for (int p = 0; p < (s == 0 ? 4 : 2); p++) begin
                src_q[s].push_back({1'b0, wd(s, p, 0)});
                src_q[s].push_back({1'b1, wd(s, p, 1)});
            end
        wait_mon(16);
        checks++; if (mon_q.size() !== 16) begin failures++; $display("FAIL wrr_count: got %0d words expected 16", mon_q.size()); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 2; w++) begin
                exp = wd(ord[k], pc[ord[k]], w);
                checks++;
                if (n >= mon_q.size() || mon_q[n] !== exp) begin
                    failures++;
                    $display("FAIL wrr_word%0d: got %h expected %h", n, n < mon_q.size() ? mon_q[n] : '0, exp);
                end
                n++;
            end
            pc[ord[k]]++;
        end
    endtask

    task automatic test_mid_packet_hold();
        do_reset(wts(1, 1, 1));
        src_q[1].push_back({1'b0, wd(1, 0, 0)});
        src_q[1].push_back({1'b1, wd(1, 0, 1)});
        src_q[2].push_back({1'b1, wd(2, 0, 0)});
        repeat (2) @(negedge clk);
        hold[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (grant_idx !== 2'd1) begin failures++; $display("FAIL hold_grant c%0d: got %0d expected 1", c, grant_idx); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy c%0d: got %b expected 1", c, busy); end
            checks++; if (bus.in_a[2] !== 1'b0) begin failures++; $display("FAIL hold_ack2 c%0d: got %b expected 0", c, bus.in_a[2]); end
        end
        hold[1] = 1'b0;
        wait_mon(3);
        checks++; if (mon_q.size() !== 3) begin failures++; $display("FAIL hold_count: got %0d expected 3", mon_q.size()); end
        checks++; if (mon_q.size() > 0 && mon_q[0] !== wd(1, 0, 0)) begin failures++; $display("FAIL hold_w0: got %h expected %h", mon_q[0], wd(1, 0, 0)); end
        checks++; if (mon_q.size() > 1 && mon_q[1] !== wd(1, 0, 1)) begin failures++; $display("FAIL hold_w1: got %h expected %h", mon_q[1], wd(1, 0, 1)); end
        checks++; if (mon_q.size() > 2 && mon_q[2] !== wd(2, 0, 0)) begin failures++; $display("FAIL hold_w2: got %h expected %h", mon_q[2], wd(2, 0, 0)); end
    endtask

    task automatic test_backpressure();
        do_reset(wts(1, 1, 1));
        bus.out_a = 1'b0;
        for (int k = 0; k < 4; k++) src_q[0].push_back({k == 3, wd(0, 0, k)});
        repeat (2) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++; if (bus.out_v !== 1'b1 || bus.out_d !== wd(0, 0, 0)) begin failures++; $display("FAIL bp_hold c%0d: got v=%b d=%h expected v=1 d=%h", c, bus.out_v, bus.out_d, wd(0, 0, 0)); end
            checks++; if (bus.in_a[0] !== 1'b0) begin failures++; $display("FAIL bp_ack c%0d: got %b expected 0", c, bus.in_a[0]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy c%0d: got %b expected 1", c, busy); end
            @(negedge clk);
        end
        bus.out_a = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_v !== 1'b1 || bus.out_d !== wd(0, 0, 1)) begin failures++; $display("FAIL bp_reload: got v=%b d=%h expected v=1 d=%h", bus.out_v, bus.out_d, wd(0, 0, 1)); end
        wait_mon(4);
        checks++; if (mon_q.size() !== 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", mon_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (k >= mon_q.size() || mon_q[k] !== wd(0, 0, k)) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", k, k < mon_q.size() ? mon_q[k] : '0, wd(0, 0, k)); end
        end
    endtask

    task automatic test_zero_weight();
        int es [6] = '{0, 2, 0, 2, 0, 2};
        do_reset(wts(1, 0, 1));
        ack1_seen = 1'b0;
        for (int s = 0; s < N_IN; s++)
            for (int p = 0; p < 3; p++) src_q[s].push_back({1'b1, wd(s, p, 0)});
        wait_mon(6);
        repeat (10) @(negedge clk);
        checks++; if (mon_q.size() !== 6) begin failures++; $display("FAIL zw_count: got %0d expected 6", mon_q.size()); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (k >= mon_q.size() || mon_q[k] !== wd(es[k], k / 2, 0)) begin failures++; $display("FAIL zw_word%0d: got %h expected %h", k, k < mon_q.size() ? mon_q[k] : '0, wd(es[k], k / 2, 0)); end
        end
        checks++; if (ack1_seen !== 1'b0) begin failures++; $display("FAIL zw_ack1: got %b expected 0", ack1_seen); end
        checks++; if (src_q[1].size() !== 3) begin failures++; $display("FAIL zw_src1_left: got %0d expected 3", src_q[1].size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zw_busy: got %b expected 0", busy); end
    endtask

    task automatic test_async_reset_mid_packet();
        do_reset(wts(1, 1, 1));
        for (int k = 0; k < 3; k++) src_q[0].push_back({k == 2, wd(0, 0, k)});
        repeat (2) @(negedge clk);
        checks++; if (bus.out_v !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ar_pre: got v=%b busy=%b expected 1 1", bus.out_v, busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.out_v !== 1'b0) begin failures++; $display("FAIL ar_out_v: got %b expected 0", bus.out_v); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy: got %b expected 0", busy); end
        checks++; if (bus.in_a !== '0) begin failures++; $display("FAIL ar_in_a: got %b expected 000", bus.in_a); end
        checks++; if (bus.out_d !== '0) begin failures++; $display("FAIL ar_out_d: got %h expected 0", bus.out_d); end
        do_reset(wts(1, 1, 1));
    endtask

`ifdef PC_OUT_ARB_STATS_EN
    task automatic test_stats();
        do_reset(wts(1, 1, 15));
        for (int p = 0; p < 70000; p++) src_q[2].push_back({1'b1, wd(2, p % 16, 0)});
        for (int c = 0; c < 90000 && src_q[2].size() > 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (src_q[2].size() !== 0) begin failures++; $display("FAIL st_drain: got %0d left expected 0", src_q[2].size()); end
        checks++; if (pkt_count[32 +: 16] !== 16'hFFFF) begin failures++; $display("FAIL st_sat: got %h expected ffff", pkt_count[32 +: 16]); end
        checks++; if (pkt_count[0 +: 16] !== 16'h0) begin failures++; $display("FAIL st_src0: got %h expected 0", pkt_count[0 +: 16]); end
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        checks++; if (pkt_count[32 +: 16] !== 16'h0) begin failures++; $display("FAIL st_clr: got %h expected 0", pkt_count[32 +: 16]); end
        mon_q.delete();
    endtask
`endif

    initial begin
        bus.out_a = 1'b1;
        test_reset();
        test_single_source();
        test_back_to_back();
        test_mid_packet_hold();
        test_backpressure();
        test_zero_weight();
        test_async_reset_mid_packet();
`ifdef PC_OUT_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
